// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a hardware clear
// sequencer. Entry 0 always reads as zero.
//
// Parameters: n = data width, r = address width (depth 2**r), NR = read ports (1..4).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clr             request a full clear sweep (sampled on rising edge, IDLE only)
//   busy            high while the clear sweep runs (registered)
//   we3/wa3/wd3     write port A
//   we4/wa4/wd4     write port B (wins over A on same-address collision)
//   ra              NR packed read addresses, port k at [k*r +: r]
//   rd              NR packed read data, port k at [k*n +: n] (combinational)
//
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.

module regfile_mp #(
  parameter int n  = 16,
  parameter int r  = 3,
  parameter int NR = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          busy,
  input  logic          we3,
  input  logic [r-1:0]  wa3,
  input  logic [n-1:0]  wd3,
  input  logic          we4,
  input  logic [r-1:0]  wa4,
  input  logic [n-1:0]  wd4,
  input  logic [NR*r-1:0] ra,
  output logic [NR*n-1:0] rd
);

  localparam int unsigned DEPTH = 2 ** r;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e         state, state_nxt;
  logic [r-1:0]   clr_cnt, clr_cnt_nxt;
  logic           sweep_c;
  logic           wr_ok_c;
  logic [n-1:0]   rf [DEPTH];

  // State, sweep counter and busy flag; busy mirrors the registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      busy    <= (state_nxt == CLEAR);
    end
  end

  // Next-state logic: IDLE accepts writes unless clr is sampled this edge.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    sweep_c     = 1'b0;
    wr_ok_c     = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else begin
          wr_ok_c = 1'b1;
        end
      end
      CLEAR: begin
        sweep_c     = 1'b1;
        clr_cnt_nxt = clr_cnt + r'(1);  // wraps to 0 after the last entry
        if (clr_cnt == r'(DEPTH - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Storage: sweep clears one entry per cycle; port B is written last so it wins.
  always_ff @(posedge clk) begin
    if (sweep_c) begin
      rf[clr_cnt] <= '0;
    end else if (wr_ok_c) begin
      if (we3 && (wa3 != '0)) rf[wa3] <= wd3;
      if (we4 && (wa4 != '0)) rf[wa4] <= wd4;
    end
  end

  // Combinational read ports; address 0 and an active sweep force zero.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [r-1:0] addr;
    logic [n-1:0] data;

    assign addr = ra[k*r +: r];

    always_comb begin
      data = '0;
      if (!busy && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (we4 && (wa4 == addr)) begin
          data = wd4;
        end else if (we3 && (wa3 == addr)) begin
          data = wd3;
        end else begin
          data = rf[addr];
        end
`else
        data = rf[addr];
`endif
      end
    end

    assign rd[k*n +: n] = data;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the 3-port, 16-bit, 8-entry register file in the datapath.
- Provides NR combinational read ports and two clocked write ports.
- Register 0 is hardwired to zero.
- A hardware clear sequencer zeroes the array after reset or on request, and flags itself busy while doing so.

Parameters:
- n, 16, data width in bits.
- r, 3, address width; depth = 2**r entries (the array is sized by r, not n).
- NR, 2, number of read ports, legal 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  request a full clear sweep; sampled on rising edge.
- busy  output  1  high while the clear sweep runs.
- we3  input  1  write enable, port A.
- wa3  input  r  write address, port A.
- wd3  input  n  write data, port A.
- we4  input  1  write enable, port B.
- wa4  input  r  write address, port B.
- wd4  input  n  write data, port B.
- ra  input  NR*r  read addresses; port k occupies bits [k*r +: r].
- rd  output  NR*n  read data; port k occupies bits [k*n +: n].

Behaviour:
- State machine has two states, IDLE and CLEAR. Counter clr_cnt is r bits wide.
- Reset assertion (async) forces the following immediately:
  - state = CLEAR
  - clr_cnt = 0
  - busy = 1
  - The array itself is not asynchronously reset.
- CLEAR, each rising edge (reset low):
  - rf[clr_cnt] <= 0, then clr_cnt increments.
  - When clr_cnt == 2**r-1 is written, the next state is IDLE, busy drops, and clr_cnt wraps to 0.
  - Sweep length is exactly 2**r cycles after reset deassertion.
- CLEAR, other rules:
  - we3/we4 are ignored.
  - All rd ports return 0.
  - clr is ignored; it does not restart the sweep.
- IDLE:
  - clr=1 at an edge → CLEAR on that edge. busy is high the following cycle. No writes are accepted in the edge that samples clr.
  - Port writes occur on the rising edge when weX=1 and waX != 0.
  - Writes to address 0 are discarded.
- Both write ports enabled with the same nonzero address: port B (wd4) wins.
- Reads are combinational, zero latency:
  - rd[k] = 0 if ra[k]==0 or busy=1.
  - Otherwise rd[k] = rf[ra[k]], subject to the bypass rule in Optional Feature.
- Reset asserted mid-sweep: the sweep restarts from entry 0.
- Reset asserted mid-write: the write is lost; the array content is undefined until the sweep completes.
- busy is a registered output, derived from state only.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first forwarding), for each read port k in IDLE with ra[k] != 0:
  - If we4 && wa4==ra[k], then rd[k] = wd4.
  - Else if we3 && wa3==ra[k], then rd[k] = wd3.
  - Else rd[k] = rf[ra[k]].
  - Forwarding is purely combinational in the same cycle.
- Undefined: rd reflects array contents only; a same-cycle write becomes visible the cycle after the edge.
- In both modes, address 0 and busy still force 0.

Test Plan:
- Reset sweep: assert reset 2 cycles, release, hold clr=0.
  - Required: busy=1 for exactly 8 cycles, then 0.
  - Required: every address afterwards reads 0x0000.
- Basic write/read, IDLE: we3=1, wa3=5, wd3=0xBEEF at edge.
  - Required: next cycle ra port0=5 gives rd port0=0xBEEF.
  - Required: ra port1=0 gives 0x0000.
- Zero register and collision:
  - Stimulus: we3=1, wa3=0, wd3=0x1234; then we3=we4=1, wa3=wa4=3, wd3=0x1111, wd4=0x2222.
  - Required: address 0 reads 0; address 3 reads 0x2222.
- Writes blocked while busy:
  - Stimulus: pulse clr; during the sweep drive we3=1, wa3=2, wd3=0xAAAA.
  - Required: busy high 8 cycles, rd=0 throughout; after the sweep address 2 reads 0x0000.
- Reset mid-sweep: assert reset at sweep cycle 4.
  - Required: clr_cnt restarts; busy lasts a full 8 cycles after release.
- Bypass (REGFILE_BYPASS_EN defined vs undefined): we4=1, wa4=6, wd4=0x0F0F, ra port0=6 in the same cycle.
  - Defined: rd port0=0x0F0F same cycle.
  - Undefined: old value same cycle, 0x0F0F next cycle.
